// File: rtl/dep_adder_issuer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dep_pkg
// Description : Shared types and constants for the dependable-adder issuer.
// Revision    : 1.0 - initial release
// ============================================================================
package dep_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_RSUB = 2'b10,
        OP_ILL  = 2'b11
    } op_t;

    localparam logic [2:0] C_ADD  = 3'b001;
    localparam logic [2:0] C_SUB  = 3'b010;
    localparam logic [2:0] C_RSUB = 3'b100;

    localparam logic [1:0] XE_OK  = 2'b10;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_ISSUE = 2'd1;
    localparam state_t S_CHECK = 2'd2;
    localparam state_t S_RESP  = 2'd3;

    // Reference {carry, sum} the adder should produce for a given request
    function automatic logic [3:0] golden_sum(input op_t op, input logic [2:0] a,
                                              input logic [2:0] b);
        logic [3:0] w_a;
        logic [3:0] w_b;
        logic [3:0] w_na;
        logic [3:0] w_nb;
        w_a  = {1'b0, a};
        w_b  = {1'b0, b};
        w_na = {1'b0, ~a};
        w_nb = {1'b0, ~b};
        case (op)
            OP_ADD:  golden_sum = w_a + w_b;
            OP_SUB:  golden_sum = w_a + w_nb + 4'd1;
            OP_RSUB: golden_sum = w_na + w_b + 4'd1;
            default: golden_sum = 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dep_adder_issuer_if.sv
`default_nettype none
// ============================================================================
// Module      : dep_adder_issuer_if
// Description : Request, response and adder-side bus of the issuer.
// Revision    : 1.0 - initial release
// ============================================================================
interface dep_adder_issuer_if;

    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [2:0] req_a;
    logic [2:0] req_b;

    logic [2:0] dut_a;
    logic [2:0] dut_b;
    logic       dut_par;
    logic [2:0] dut_c;
    logic [2:0] dut_x;
    logic       dut_xc;
    logic [1:0] dut_xe;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_sum;
    logic       rsp_err;
    logic [2:0] rsp_retries;

    // Issuer side
    modport slave (
        input  req_valid, req_op, req_a, req_b,
        input  dut_x, dut_xc, dut_xe,
        input  rsp_ready,
        output req_ready,
        output dut_a, dut_b, dut_par, dut_c,
        output rsp_valid, rsp_sum, rsp_err, rsp_retries
    );

    // Requester / adder side
    modport master (
        output req_valid, req_op, req_a, req_b,
        output dut_x, dut_xc, dut_xe,
        output rsp_ready,
        input  req_ready,
        input  dut_a, dut_b, dut_par, dut_c,
        input  rsp_valid, rsp_sum, rsp_err, rsp_retries
    );

endinterface
`default_nettype wire

// File: rtl/dep_adder_issuer_operand_encoder.sv
`default_nettype none
// ============================================================================
// Module      : dep_operand_encoder
// Description : op/a/b -> one-hot control, odd parity bit and reference sum.
// Revision    : 1.0 - initial release
// ============================================================================
module dep_operand_encoder
    import dep_pkg::*;
(
    input  op_t        op,
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [2:0] c,
    output logic       par,
    output logic [3:0] gold
);

    always_comb begin
        c = 3'b000;
        case (op)
            OP_ADD:  c = C_ADD;
            OP_SUB:  c = C_SUB;
            OP_RSUB: c = C_RSUB;
            default: c = 3'b000;
        endcase
    end

    // Odd parity across a, b and par together
    assign par  = ~(^a ^ ^b);
    assign gold = golden_sum(op, a, b);

endmodule
`default_nettype wire

// File: rtl/dep_adder_issuer.sv
`default_nettype none
// ============================================================================
// Module      : dep_adder_issuer
// Description : Issues ADD/SUB/RSUB to the TMR adder, checks and retries.
//               Optional DEP_GOLDEN_CHECK_EN adds a local reference compare.
// Revision    : 1.0 - initial release
// ============================================================================
module dep_adder_issuer
    import dep_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int WAIT_CYCLES = 1,
    parameter int MAX_RETRY   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dep_adder_issuer_if.slave    bus
);

    localparam int              c_cnt_w     = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_wait_load = c_cnt_w'(WAIT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(1);
    localparam logic [2:0]      c_retry_max = 3'(MAX_RETRY);

    state_t               r_state;
    state_t               w_state_nxt;
    op_t                  r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [c_cnt_w-1:0]   r_wait;
    logic [2:0]           r_retries;
    logic [2:0]           r_x;
    logic                 r_xc;
    logic [1:0]           r_xe;
    logic [3:0]           r_rsp_sum;
    logic                 r_rsp_err;
    logic                 r_req_ready;

    logic [2:0]           w_c;
    logic                 w_par;
    logic [3:0]           w_gold;
    logic                 w_pass;
    logic                 w_accept;
    logic                 w_issuing;

    dep_operand_encoder u_encoder (
        .op   (r_op),
        .a    (r_a),
        .b    (r_b),
        .c    (w_c),
        .par  (w_par),
        .gold (w_gold)
    );

`ifdef DEP_GOLDEN_CHECK_EN
    assign w_pass = (r_xe == XE_OK) && ({r_xc, r_x} == w_gold);
`else
    logic w_unused_gold;
    assign w_unused_gold = ^w_gold;
    assign w_pass        = (r_xe == XE_OK);
`endif

    assign w_accept  = (r_state == S_IDLE) && bus.req_valid && r_req_ready;
    assign w_issuing = (r_state == S_ISSUE);

    // An illegal op spends one idle cycle in CHECK so its response lands
    // two cycles after accept, without ever driving the adder.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (op_t'(bus.req_op) == OP_ILL) ? S_CHECK : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_wait == c_wait_last) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((r_op == OP_ILL) || w_pass || (r_retries >= c_retry_max)) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= OP_ADD;
            r_a         <= '0;
            r_b         <= '0;
            r_wait      <= '0;
            r_retries   <= 3'd0;
            r_x         <= 3'd0;
            r_xc        <= 1'b0;
            r_xe        <= 2'b00;
            r_rsp_sum   <= 4'd0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= op_t'(bus.req_op);
                        r_a       <= bus.req_a;
                        r_b       <= bus.req_b;
                        r_wait    <= c_wait_load;
                        r_retries <= 3'd0;
                    end
                end
                S_ISSUE: begin
                    r_wait <= r_wait - c_wait_last;
                    if (r_wait == c_wait_last) begin
                        r_x  <= bus.dut_x;
                        r_xc <= bus.dut_xc;
                        r_xe <= bus.dut_xe;
                    end
                end
                S_CHECK: begin
                    if (r_op == OP_ILL) begin
                        r_rsp_sum <= 4'd0;
                        r_rsp_err <= 1'b1;
                    end else if (w_pass) begin
                        r_rsp_sum <= {r_xc, r_x};
                        r_rsp_err <= 1'b0;
                    end else if (r_retries < c_retry_max) begin
                        r_retries <= r_retries + 3'd1;
                        r_wait    <= c_wait_load;
                    end else begin
                        r_rsp_sum <= {r_xc, r_x};
                        r_rsp_err <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_retries <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.dut_a       = w_issuing ? r_a   : '0;
    assign bus.dut_b       = w_issuing ? r_b   : '0;
    assign bus.dut_par     = w_issuing ? w_par : 1'b0;
    assign bus.dut_c       = w_issuing ? w_c   : 3'b000;
    assign bus.rsp_valid   = (r_state == S_RESP);
    assign bus.rsp_sum     = r_rsp_sum;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_retries = r_retries;

endmodule
`default_nettype wire
